lcv_mul_acc_pipe: RTL and testbench

Parametrised, pipelined signed multiply-accumulate unit, the DSP-mapped successor of the fixed 16x16 MAC blocks. It adds configurable operand and accumulator widths and a persistent accumulator with load, accumulate, subtract and add-only modes. It also adds optional saturation and valid/ready flow control on both sides. It feeds filter and dot-product datapaths, and its multiplier is marked for DSP inference.

---
 rtl/lcv_mul_acc_pipe.sv | 158 +++++++++++++++
 tb/tb_lcv_mul_acc_pipe.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcv_mul_acc_pipe.sv
// Pipelined signed multiply-accumulate unit: input register, DSP product register and a
// persistent accumulator/output register, with optional saturation and valid/ready flow control.
module lcv_mul_acc_pipe #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int ACC_WIDTH = 40,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [A_WIDTH-1:0]   in_a,
    input  logic signed [B_WIDTH-1:0]   in_b,
    input  logic signed [ACC_WIDTH-1:0] in_c,
    input  logic [1:0]                  in_op,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] out_data,
    output logic                        out_sat,
    output logic                        out_last
);

    localparam int PW   = A_WIDTH + B_WIDTH;
    localparam int EW   = ACC_WIDTH + 2;
    localparam int TOPW = EW - ACC_WIDTH + 1;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_ACC  = 2'd1,
        OP_SUB  = 2'd2,
        OP_ADD  = 2'd3
    } op_e;

    generate
        if (ACC_WIDTH < PW + 1) begin : g_width_check
            $error("lcv_mul_acc_pipe: ACC_WIDTH must be >= A_WIDTH+B_WIDTH+1");
        end
    endgenerate

    logic en;

    logic                        v0_q;
    logic signed [A_WIDTH-1:0]   a0_q;
    logic signed [B_WIDTH-1:0]   b0_q;
    logic signed [ACC_WIDTH-1:0] c0_q;
    op_e                         op0_q;
    logic                        last0_q;

    logic                        v1_q;
    logic signed [EW-1:0]        p1_q;
    logic signed [EW-1:0]        p1_d;
    logic signed [ACC_WIDTH-1:0] c1_q;
    op_e                         op1_q;
    logic                        last1_q;

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic                        sat_q;
    logic                        sat_d;
    logic                        last_q;
    logic                        ovalid_q;

    logic signed [PW-1:0]        aExt;
    logic signed [PW-1:0]        bExt;
    (* use_dsp = "yes" *) logic signed [PW-1:0] prod;
    logic signed [EW-1:0]        accExt;
    logic signed [EW-1:0]        cExt;
    logic signed [EW-1:0]        rSum;
    logic [TOPW-1:0]             topBits;
    logic                        ovf;

    // A stalled output register freezes the whole pipe, so nothing is lost or duplicated.
    assign en       = !(ovalid_q && !out_ready);
    assign in_ready = en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
        end else if (en) begin
            v0_q <= in_valid && in_ready;
            v1_q <= v0_q;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            a0_q    <= in_a;
            b0_q    <= in_b;
            c0_q    <= in_c;
            op0_q   <= op_e'(in_op);
            last0_q <= in_last;
            p1_q    <= p1_d;
            c1_q    <= c0_q;
            op1_q   <= op0_q;
            last1_q <= last0_q;
        end
    end

    // Full-width signed product, sign-extended to the accumulation width.
    assign aExt = {{B_WIDTH{a0_q[A_WIDTH-1]}}, a0_q};
    assign bExt = {{A_WIDTH{b0_q[B_WIDTH-1]}}, b0_q};
    assign prod = aExt * bExt;
    assign p1_d = {{(EW-PW){prod[PW-1]}}, prod};

    always_comb begin
        accExt = {{(EW-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q};
        cExt   = {{(EW-ACC_WIDTH){c1_q[ACC_WIDTH-1]}}, c1_q};
        rSum   = cExt;
        case (op1_q)
            OP_LOAD: rSum = p1_q + cExt;
            OP_ACC:  rSum = accExt + p1_q + cExt;
            OP_SUB:  rSum = accExt - p1_q + cExt;
            OP_ADD:  rSum = accExt + cExt;
            default: rSum = cExt;
        endcase
    end

    // The sum is in range only when its top bits are all copies of the sign.
    always_comb begin
        topBits = rSum[EW-1:ACC_WIDTH-1];
        ovf     = !((topBits == '0) || (topBits == '1));
        acc_d   = rSum[ACC_WIDTH-1:0];
        sat_d   = ovf;
        if (ovf && SATURATE) begin
            acc_d = rSum[EW-1] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            sat_q    <= 1'b0;
            last_q   <= 1'b0;
            ovalid_q <= 1'b0;
        end else if (en) begin
            if (v1_q) begin
                acc_q    <= acc_d;
                sat_q    <= sat_d;
                last_q   <= last1_q;
                ovalid_q <= 1'b1;
            end else begin
                ovalid_q <= 1'b0;
            end
        end
    end

    assign out_valid = ovalid_q;
    assign out_data  = acc_q;
    assign out_sat   = sat_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_lcv_mul_acc_pipe.sv
// Bench for lcv_mul_acc_pipe: a saturating and a wrapping instance share one input stream;
// directed vectors, stall and reset sequences, then random traffic against a plain-arithmetic model.
module tb_lcv_mul_acc_pipe;

    localparam int AW = 16;
    localparam int BW = 16;
    localparam int W  = 40;
    localparam int NT = 16;
    localparam longint MAXV = (longint'(1) << (W-1)) - 1;
    localparam longint MINV = -(longint'(1) << (W-1));

    typedef struct {
        logic [1:0] op;
        longint     a;
        longint     b;
        longint     c;
        bit         last;
        longint     e1;
        bit         s1;
        longint     e0;
        bit         s0;
    } vec_t;

    typedef struct {
        longint d1;
        bit     s1;
        longint d0;
        bit     s0;
        bit     last;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic [AW-1:0]       in_a = '0;
    logic [BW-1:0]       in_b = '0;
    logic [W-1:0]        in_c = '0;
    logic [1:0]          in_op = '0;
    logic                in_last = 1'b0;
    logic                out_ready = 1'b1;
    logic                inReady1, inReady0;
    logic                ov1, ov0, os1, os0, ol1, ol0;
    logic [W-1:0]        od1, od0;

    int                  nChecks = 0;
    int                  nFail = 0;
    int                  rdyMode = 0;
    longint              m1 = 0;
    longint              m0 = 0;
    exp_t                expQ[$];
    vec_t                tbl[NT];

    lcv_mul_acc_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(W), .SATURATE(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady1),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_op(in_op), .in_last(in_last),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_sat(os1), .out_last(ol1)
    );

    lcv_mul_acc_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(W), .SATURATE(1'b0)) dutWrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady0),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_op(in_op), .in_last(in_last),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_sat(os0), .out_last(ol0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (rdyMode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sx(input logic [W-1:0] v);
        logic signed [W-1:0] s;
        s = v;
        return longint'(s);
    endfunction

    // Reference: exact integer sum, then clamp or wrap into the accumulator range.
    function automatic void modelStep(input logic [1:0] op, input longint a, input longint b,
                                      input longint c, output longint d1, output bit s1,
                                      output longint d0, output bit s0);
        longint p, r1, r0;
        logic [W-1:0] t;
        p = a * b;
        case (op)
            2'd0:    begin r1 = p + c;      r0 = p + c;      end
            2'd1:    begin r1 = m1 + p + c; r0 = m0 + p + c; end
            2'd2:    begin r1 = m1 - p + c; r0 = m0 - p + c; end
            default: begin r1 = m1 + c;     r0 = m0 + c;     end
        endcase
        if (r1 > MAXV)      begin d1 = MAXV; s1 = 1'b1; end
        else if (r1 < MINV) begin d1 = MINV; s1 = 1'b1; end
        else                begin d1 = r1;   s1 = 1'b0; end
        s0 = (r0 > MAXV) || (r0 < MINV);
        t  = r0[W-1:0];
        d0 = sx(t);
        m1 = d1;
        m0 = d0;
    endfunction

    always @(negedge clk) begin
        if (!rst && ov1 && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("data_sat", sx(od1), e.d1);
                checkOutput("sat_sat", os1, e.s1);
                checkOutput("last_sat", ol1, e.last);
                checkOutput("valid_wrap", ov0, 1);
                checkOutput("data_wrap", sx(od0), e.d0);
                checkOutput("sat_wrap", os0, e.s0);
                checkOutput("last_wrap", ol0, e.last);
            end
        end
    end

    // Presents one beat starting just after a rising edge and returns just after its accept edge.
    task automatic sendBeat(input vec_t v, input bit useModel);
        bit ok, rdy;
        exp_t e;
        longint d1, d0;
        bit s1, s0;
        ok = 1'b0;
        in_a = v.a[AW-1:0];
        in_b = v.b[BW-1:0];
        in_c = v.c[W-1:0];
        in_op = v.op;
        in_last = v.last;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            rdy = inReady1;
            @(posedge clk);
            if (rdy) ok = 1'b1;
        end
        #1;
        in_valid = 1'b0;
        if (!ok) begin
            checkOutput("accept_timeout", 0, 1);
        end else begin
            modelStep(v.op, v.a, v.b, v.c, d1, s1, d0, s0);
            if (useModel) e = '{d1: d1, s1: s1, d0: d0, s0: s0, last: v.last};
            else          e = '{d1: v.e1, s1: v.s1, d0: v.e0, s0: v.s0, last: v.last};
            expQ.push_back(e);
        end
    endtask

    task automatic waitDrain();
        for (int k = 0; k < 1000 && expQ.size() != 0; k++) @(posedge clk);
        if (expQ.size() != 0) checkOutput("drain_timeout", expQ.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] op, input longint a, input longint b,
                                input longint c, input bit last, input longint e1, input bit s1,
                                input longint e0, input bit s0);
        vec_t v;
        v = '{op: op, a: a, b: b, c: c, last: last, e1: e1, s1: s1, e0: e0, s0: s0};
        return v;
    endfunction

    task automatic applyStimulus(input int n);
        vec_t v;
        logic signed [AW-1:0] ra;
        logic signed [BW-1:0] rb;
        logic signed [W-1:0]  rc;
        rdyMode = 1;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(4) == 0) begin
                @(posedge clk);
                #1;
            end
            ra = AW'($urandom);
            rb = BW'($urandom);
            case ($urandom_range(3))
                0:       rc = W'({$urandom, $urandom});
                1:       rc = W'($signed($urandom_range(2000)) - 1000);
                2:       rc = '0;
                default: rc = W'(MAXV - longint'($urandom_range(1000000)));
            endcase
            v = mk(2'($urandom_range(3)), longint'(ra), longint'(rb), longint'(rc),
                   1'($urandom), 0, 0, 0, 0);
            sendBeat(v, 1'b1);
        end
        rdyMode = 0;
    endtask

    initial begin
        longint held;
        tbl[0]  = mk(2'd0, 3, -4, 10, 0, -2, 0, -2, 0);
        tbl[1]  = mk(2'd0, 100, 200, 0, 0, 20000, 0, 20000, 0);
        tbl[2]  = mk(2'd1, 1000, 1000, 0, 0, 1020000, 0, 1020000, 0);
        tbl[3]  = mk(2'd1, 1000, 1000, 0, 0, 2020000, 0, 2020000, 0);
        tbl[4]  = mk(2'd1, 1000, 1000, 0, 0, 3020000, 0, 3020000, 0);
        tbl[5]  = mk(2'd1, 1000, 1000, 0, 0, 4020000, 0, 4020000, 0);
        tbl[6]  = mk(2'd1, 1000, 1000, 0, 1, 5020000, 0, 5020000, 0);
        tbl[7]  = mk(2'd0, 0, 0, 50, 0, 50, 0, 50, 0);
        tbl[8]  = mk(2'd2, 7, 8, 0, 0, -6, 0, -6, 0);
        tbl[9]  = mk(2'd3, 9, 9, -4, 1, -10, 0, -10, 0);
        tbl[10] = mk(2'd0, 0, 0, MAXV, 0, MAXV, 0, MAXV, 0);
        tbl[11] = mk(2'd1, 1, 1, 0, 1, MAXV, 1, MINV, 1);
        tbl[12] = mk(2'd1, 0, 0, 0, 0, MAXV, 0, MINV, 0);
        tbl[13] = mk(2'd0, 0, 0, MINV, 0, MINV, 0, MINV, 0);
        tbl[14] = mk(2'd2, 1, 1, 0, 0, MINV, 1, MAXV, 1);
        tbl[15] = mk(2'd1, -32768, -32768, 0, 1, MINV + 1073741824, 0, MINV + 1073741823, 1);

        #12;
        checkOutput("reset_valid", ov1, 0);
        checkOutput("reset_data", sx(od1), 0);
        checkOutput("reset_sat", os1, 0);
        checkOutput("reset_last", ol1, 0);
        checkOutput("reset_inready", inReady1, 1);
        checkOutput("reset_valid_wrap", ov0, 0);
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;

        sendBeat(tbl[0], 1'b0);
        @(negedge clk);
        checkOutput("latency_edge0", ov1, 0);
        @(negedge clk);
        checkOutput("latency_edge1", ov1, 0);
        @(negedge clk);
        checkOutput("latency_edge2", ov1, 1);
        waitDrain();

        for (int i = 1; i < NT; i++) sendBeat(tbl[i], 1'b0);
        waitDrain();

        fork
            begin
                sendBeat(mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
                for (int k = 1; k <= 8; k++)
                    sendBeat(mk(2'd1, 1, 1, 0, (k == 8), k, 0, k, 0), 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                rdyMode = 2;
                @(negedge clk);
                held = sx(od1);
                checkOutput("stall_valid", ov1, 1);
                checkOutput("stall_inready", inReady1, 0);
                checkOutput("stall_inready_wrap", inReady0, 0);
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("stall_hold", sx(od1), held);
                    checkOutput("stall_inready", inReady1, 0);
                end
                rdyMode = 0;
            end
        join
        waitDrain();

        applyStimulus(300);
        waitDrain();

        sendBeat(mk(2'd0, 5, 5, 0, 0, 0, 0, 0, 0), 1'b0);
        in_a = 16'd6; in_b = 16'd6; in_c = '0; in_op = 2'd0; in_valid = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        checkOutput("midreset_valid", ov1, 0);
        checkOutput("midreset_data", sx(od1), 0);
        checkOutput("midreset_sat", os1, 0);
        checkOutput("midreset_data_wrap", sx(od0), 0);
        void'(expQ.pop_back());
        m1 = 0;
        m0 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        sendBeat(mk(2'd0, 2, 2, 0, 1, 4, 0, 4, 0), 1'b0);
        waitDrain();
        repeat (10) @(posedge clk);
        checkOutput("post_reset_idle", ov1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
